// File: rtl/axi_lite_pkg.sv
//------------------------------------------------------------------------------
// Module   : axi_lite_pkg
// Brief    : Shared AXI-Lite response codes and response type.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package axi_lite_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
  localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;

endpackage : axi_lite_pkg

`default_nettype wire

// File: rtl/axi_bram_responder_if.sv
//------------------------------------------------------------------------------
// Module   : axi_bram_responder_if
// Brief    : AXI-Lite write/read channel bundle with initiator and target views.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface axi_bram_responder_if
  import axi_lite_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 8,
  parameter int AXI_DATA_WIDTH = 16
);

  logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr;
  logic                        axi_awvalid;
  logic                        axi_awready;
  logic [AXI_DATA_WIDTH-1:0]   axi_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb;
  logic                        axi_wvalid;
  logic                        axi_wready;
  axi_resp_t                   axi_bresp;
  logic                        axi_bvalid;
  logic                        axi_bready;
  logic [AXI_ADDR_WIDTH-1:0]   axi_araddr;
  logic                        axi_arvalid;
  logic                        axi_arready;
  logic [AXI_DATA_WIDTH-1:0]   axi_rdata;
  axi_resp_t                   axi_rresp;
  logic                        axi_rvalid;
  logic                        axi_rready;

  modport master (
    output axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid,
           axi_bready, axi_araddr, axi_arvalid, axi_rready,
    input  axi_awready, axi_wready, axi_bresp, axi_bvalid,
           axi_arready, axi_rdata, axi_rresp, axi_rvalid
  );

  modport slave (
    input  axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid,
           axi_bready, axi_araddr, axi_arvalid, axi_rready,
    output axi_awready, axi_wready, axi_bresp, axi_bvalid,
           axi_arready, axi_rdata, axi_rresp, axi_rvalid
  );

endinterface : axi_bram_responder_if

`default_nettype wire

// File: rtl/bram_sdp.sv
//------------------------------------------------------------------------------
// Module   : bram_sdp
// Brief    : Simple dual-port RAM, byte-enabled write port, registered read port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bram_sdp #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  wire logic                    clk,
  input  wire logic                    i_we,
  input  wire logic [ADDR_WIDTH-1:0]   i_waddr,
  input  wire logic [DATA_WIDTH-1:0]   i_wdata,
  input  wire logic [DATA_WIDTH/8-1:0] i_be,
  input  wire logic                    i_re,
  input  wire logic [ADDR_WIDTH-1:0]   i_raddr,
  output logic      [DATA_WIDTH-1:0]   o_rdata
);

  localparam int c_lanes = DATA_WIDTH / 8;
  localparam int c_depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [0:c_depth-1];
  logic [DATA_WIDTH-1:0] r_rdata;

  // No reset on the array or read register so the tools map this onto block RAM;
  // a read colliding with a write returns the old word.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < c_lanes; i++) begin
        if (i_be[i]) begin
          r_mem[i_waddr][i*8 +: 8] <= i_wdata[i*8 +: 8];
        end
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule : bram_sdp

`default_nettype wire

// File: rtl/axi_bram_responder.sv
//------------------------------------------------------------------------------
// Module   : axi_bram_responder
// Brief    : Zero-wait-state AXI-Lite target backed by block RAM, OKAY-only.
//            Define AXI_BRAM_WSTRB_EN to honour per-byte write strobes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module axi_bram_responder
  import axi_lite_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 8,
  parameter int AXI_DATA_WIDTH = 16
) (
  input wire logic            clk,
  input wire logic            reset,
  axi_bram_responder_if.slave axi
);

  localparam int c_strb_w = AXI_DATA_WIDTH / 8;

  logic                      r_aw_full;
  logic                      r_w_full;
  logic                      r_bvalid;
  logic [AXI_ADDR_WIDTH-1:0] r_aw_addr;
  logic [AXI_DATA_WIDTH-1:0] r_w_data;
  logic                      r_ar_busy;
  logic                      r_rvalid;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;

  logic                      w_awready;
  logic                      w_wready;
  logic                      w_arready;
  logic                      w_aw_hs;
  logic                      w_w_hs;
  logic                      w_b_hs;
  logic                      w_ar_hs;
  logic                      w_r_hs;
  logic                      w_commit;
  logic [c_strb_w-1:0]       w_byte_en;
  logic [AXI_DATA_WIDTH-1:0] w_ram_q;

  assign w_awready = !reset && !r_aw_full && !r_bvalid;
  assign w_wready  = !reset && !r_w_full  && !r_bvalid;
  assign w_arready = !reset && !r_rvalid  && !r_ar_busy;

  assign w_aw_hs = axi.axi_awvalid && w_awready;
  assign w_w_hs  = axi.axi_wvalid  && w_wready;
  assign w_b_hs  = r_bvalid && axi.axi_bready;
  assign w_ar_hs = axi.axi_arvalid && w_arready;
  assign w_r_hs  = r_rvalid && axi.axi_rready;

  // Holding registers filled while reset is asserted must not reach the RAM.
  assign w_commit = r_aw_full && r_w_full && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
      end
      if (w_commit) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
        r_bvalid  <= 1'b1;
      end else if (w_b_hs) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_aw_hs) begin
      r_aw_addr <= axi.axi_awaddr;
    end
    if (w_w_hs) begin
      r_w_data <= axi.axi_wdata;
    end
  end

`ifdef AXI_BRAM_WSTRB_EN
  logic [c_strb_w-1:0] r_w_strb;

  always_ff @(posedge clk) begin
    if (w_w_hs) begin
      r_w_strb <= axi.axi_wstrb;
    end
  end

  assign w_byte_en = r_w_strb;
`else
  logic w_unused_wstrb;

  assign w_unused_wstrb = ^axi.axi_wstrb;
  assign w_byte_en      = '1;
`endif

  bram_sdp #(
    .ADDR_WIDTH (AXI_ADDR_WIDTH),
    .DATA_WIDTH (AXI_DATA_WIDTH)
  ) u_bram_sdp (
    .clk     (clk),
    .i_we    (w_commit),
    .i_waddr (r_aw_addr),
    .i_wdata (r_w_data),
    .i_be    (w_byte_en),
    .i_re    (w_ar_hs),
    .i_raddr (axi.axi_araddr),
    .o_rdata (w_ram_q)
  );

  // RAM output is valid the edge after AR; capture it so rdata stays put under back-pressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ar_busy <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      if (w_ar_hs) begin
        r_ar_busy <= 1'b1;
      end
      if (r_ar_busy) begin
        r_ar_busy <= 1'b0;
        r_rvalid  <= 1'b1;
        r_rdata   <= w_ram_q;
      end else if (w_r_hs) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign axi.axi_awready = w_awready;
  assign axi.axi_wready  = w_wready;
  assign axi.axi_bresp   = AXI_RESP_OKAY;
  assign axi.axi_bvalid  = r_bvalid;
  assign axi.axi_arready = w_arready;
  assign axi.axi_rdata   = r_rdata;
  assign axi.axi_rresp   = AXI_RESP_OKAY;
  assign axi.axi_rvalid  = r_rvalid;

endmodule : axi_bram_responder

`default_nettype wire

// File: doc/axi_bram_responder.md
# axi_bram_responder

AXI-Lite responder backed by on-chip block RAM; the target-side counterpart of the SRAM tester's AXI-Lite initiator. Accepts word-addressed writes and reads on independent channels and returns OKAY responses. Used as a drop-in, zero-wait-state stand-in for `axi_sram_controller` when bringing up initiators, and as a small scratch memory.

## Interface
Parameters:
- `AXI_ADDR_WIDTH`, 8: word address width; depth = 2^AXI_ADDR_WIDTH words.
- `AXI_DATA_WIDTH`, 16: data width; a multiple of 8.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: sole clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `axi_awaddr` input AXI_ADDR_WIDTH: write word address.
- `axi_awvalid` input 1 / `axi_awready` output 1: write address handshake.
- `axi_wdata` input AXI_DATA_WIDTH: write data.
- `axi_wstrb` input AXI_DATA_WIDTH/8: byte-lane strobes.
- `axi_wvalid` input 1 / `axi_wready` output 1: write data handshake.
- `axi_bresp` output 2: write response, always OKAY (2'b00).
- `axi_bvalid` output 1 / `axi_bready` input 1: write response handshake.
- `axi_araddr` input AXI_ADDR_WIDTH: read word address.
- `axi_arvalid` input 1 / `axi_arready` output 1: read address handshake.
- `axi_rdata` output AXI_DATA_WIDTH: read data.
- `axi_rresp` output 2: always OKAY.
- `axi_rvalid` output 1 / `axi_rready` input 1: read data handshake.

## Operation
- Write path: holding registers for address (`aw_full`) and data (`w_full`), filled independently in either order or the same cycle.
- `axi_awready = !reset & !aw_full & !axi_bvalid`; `axi_wready = !reset & !w_full & !axi_bvalid`.
- When both full: commit to memory, clear both flags, set `axi_bvalid`, all on the same edge.
- `axi_bvalid` holds until `axi_bready`; clears on that edge.
- Read path: `axi_arready = !reset & !axi_rvalid & !ar_busy`.
- AR handshake: address presented to RAM read port, `ar_busy` set; next edge `axi_rdata` registered, `axi_rvalid` set, `ar_busy` cleared.
- `axi_rdata` held stable while `axi_rvalid & !axi_rready`; `axi_rvalid` clears on R handshake.
- Read and write paths independent; read of an address committed on the same edge returns pre-write data.
- Addresses use all AXI_ADDR_WIDTH bits; no out-of-range case, no wrap logic.

## Timing
- Reset values: `axi_bvalid`=0, `axi_rvalid`=0, `axi_rdata`=0, resp=2'b00, all readys 0 during reset, 1 the cycle after. RAM contents not cleared.
- Write: AW and W handshakes complete by edge N → memory written and `axi_bvalid`=1 after edge N+1; with `axi_bready` high, B handshake at N+2; next AW/W accepted at N+3 or later.
- Read: AR at edge N → `axi_rvalid`=1 after edge N+1; with `axi_rready` high, next AR accepted at N+3 or later.
- AW handshake with W absent: `axi_awready` low until commit/B complete; W may arrive any later cycle.
- Back-pressure on B or R: no further AW/W or AR accepted, respectively.
- Reset mid-transaction: holding flags, `ar_busy`, valids cleared; pending responses dropped; a write already committed stays in RAM.

## Configuration
- `AXI_BRAM_WSTRB_EN` defined: only byte lanes with `axi_wstrb[i]`=1 written; `axi_wstrb`=0 is a no-op write that still returns OKAY B.
- Undefined: `axi_wstrb` ignored (lint-waived), full word written every commit.

## Structure
- Shared package `axi_lite_pkg`: `AXI_RESP_OKAY`=2'b00, `AXI_RESP_SLVERR`=2'b10, 2-bit resp typedef.
- Sub-module `bram_sdp`: simple dual-port RAM, one write port with per-byte enables, one registered read port; no reset on array; infers iCE40 EBR.

## Test plan
- Write 0x1234 to addr 0x05 (AW and W same cycle), then read 0x05 → `axi_bvalid` at N+1, `axi_rvalid` at N+1 after AR, `axi_rdata`=0x1234, resp 00.
- W 0xBEEF three cycles before AW addr 0x10 → no B until AW accepted; read 0x10 → 0xBEEF.
- `axi_bready` low 5 cycles after write → `axi_bvalid` held, `axi_awready`/`axi_wready` stay 0; `axi_rready` low 5 cycles → `axi_rdata` stable.
- With `AXI_BRAM_WSTRB_EN`: 0xAAAA to 0x03, then 0x5555 with strb 2'b01 → reads 0xAA55; without macro → 0x5555.
- Same-edge commit of 0x2222 to 0x07 (prior 0x1111) and AR 0x07 → read 0x1111; second read → 0x2222.
- Full sweep all addresses with tester pattern (addr as data), then reset asserted mid-read → `axi_rvalid`=0 next cycle, readback after reset still matches.
